// File: rtl/ex_pkg.sv
// Shared encodings for the pipelined execute stage: ALU commands, shifter
// types, controller states, NZCV bit positions and the carried control bits.
package ex_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001,
    CMD_MUL = 4'b1010
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } ex_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control bits that travel with an instruction into the EX/MEM register.
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic branch_taken;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Upstream handshake, downstream stall/flush and EX/MEM result bundle of the
// execute stage. The stage itself uses the slave side.
interface ex_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     pc_in;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  status_w_en_in;
  logic                  branch_taken_in;
  logic                  immd;
  logic [3:0]            exe_cmd;
  logic [DATA_W-1:0]     val_rn;
  logic [DATA_W-1:0]     val_rm;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [23:0]           signed_immd_24;
  logic [11:0]           shift_operand;
  logic                  out_stall;
  logic                  flush;

  logic                  out_valid;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic                  branch_taken_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [DATA_W-1:0]     alu_res;
  logic [DATA_W-1:0]     val_rm_out;
  logic [ADDR_W-1:0]     branch_address;
  logic [3:0]            status;

  modport master (
    output in_valid, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in,
           branch_taken_in, immd, exe_cmd, val_rn, val_rm, dest_in,
           signed_immd_24, shift_operand, out_stall, flush,
    input  in_ready, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           branch_taken_out, dest_out, alu_res, val_rm_out, branch_address, status
  );

  modport slave (
    input  in_valid, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in,
           branch_taken_in, immd, exe_cmd, val_rn, val_rm, dest_in,
           signed_immd_24, shift_operand, out_stall, flush,
    output in_ready, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           branch_taken_out, dest_out, alu_res, val_rm_out, branch_address, status
  );
endinterface

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for DATA_W
// cycles, keeping only the low DATA_W bits of the product.
module ex_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) busy_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done flags the edge that performs the final step; product is valid after it.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(DATA_W - 1)) && !abort;
  assign product = acc_q;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with EX/MEM output register, NZCV status, live-carry ADC/SBC
// and a multi-cycle multiply that holds the upstream handshake while it runs.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  ex_stage_pipe_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  if (DATA_W < 16 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("ex_stage_pipe: DATA_W must be a power of two and at least 16");
  end

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [SH_W-1:0]   n);
    return (x >> n) | (x << (DATA_W - int'(n)));
  endfunction

  ex_state_e             state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  ex_ctrl_t              out_ctrl_q, out_ctrl_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [DATA_W-1:0]     rm_q, rm_d;
  logic [ADDR_W-1:0]     br_q, br_d;
  logic [3:0]            status_q, status_d;
  ex_ctrl_t              m_ctrl_q, m_ctrl_d;
  logic                  m_swe_q, m_swe_d;
  logic [REG_ADDR_W-1:0] m_dest_q, m_dest_d;
  logic [DATA_W-1:0]     m_rm_q, m_rm_d;
  logic [ADDR_W-1:0]     m_br_q, m_br_d;

  logic [SH_W-1:0]   sh_amt, rot_amt;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_nzcv;
  logic              alu_arith;
  logic              alu_flag_we;
  logic [ADDR_W-1:0] br_addr;
  ex_ctrl_t          in_ctrl;
  logic              in_ready, out_free, accept, load, mul_start;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;

  // Operand 2: address offset, rotated immediate or shifted register.
  always_comb begin
    sh_amt  = SH_W'(int'(bus.shift_operand[11:7]) % DATA_W);
    rot_amt = SH_W'((2 * int'(bus.shift_operand[11:8])) % DATA_W);
    val2    = '0;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = DATA_W'(bus.shift_operand);
    end else if (bus.immd) begin
      val2 = rotr(DATA_W'(bus.shift_operand[7:0]), rot_amt);
    end else begin
      case (bus.shift_operand[6:5])
        SH_LSL: val2 = bus.val_rm << sh_amt;
        SH_LSR: val2 = bus.val_rm >> sh_amt;
        SH_ASR: val2 = DATA_W'($signed(bus.val_rm) >>> sh_amt);
        SH_ROR: val2 = rotr(bus.val_rm, sh_amt);
        default: val2 = bus.val_rm;
      endcase
    end
  end

  // One adder serves ADD/ADC/SUB/SBC; subtraction is a + ~b + carry-in.
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    case (bus.exe_cmd)
      CMD_ADC: add_cin = status_q[FLAG_C];
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1; end
      CMD_SBC: begin add_b = ~val2; add_cin = status_q[FLAG_C]; end
      default: ;
    endcase
    add_sum = {1'b0, bus.val_rn} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

    alu_res     = '0;
    alu_arith   = 1'b0;
    alu_flag_we = 1'b1;
    case (bus.exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res   = add_sum[DATA_W-1:0];
        alu_arith = 1'b1;
      end
      CMD_AND: alu_res = bus.val_rn & val2;
      CMD_ORR: alu_res = bus.val_rn | val2;
      CMD_EOR: alu_res = bus.val_rn ^ val2;
      default: alu_flag_we = 1'b0;
    endcase

    alu_nzcv         = status_q;
    alu_nzcv[FLAG_N] = alu_res[DATA_W-1];
    alu_nzcv[FLAG_Z] = (alu_res == '0);
    if (alu_arith) begin
      alu_nzcv[FLAG_C] = add_sum[DATA_W];
      alu_nzcv[FLAG_V] = (bus.val_rn[DATA_W-1] == add_b[DATA_W-1]) &&
                         (add_sum[DATA_W-1] != bus.val_rn[DATA_W-1]);
    end
  end

  assign br_addr = bus.pc_in +
                   ADDR_W'({{ADDR_W{bus.signed_immd_24[23]}}, bus.signed_immd_24, 2'b00});

  always_comb begin
    in_ctrl.wb_en        = bus.wb_en_in;
    in_ctrl.mem_r_en     = bus.mem_r_en_in;
    in_ctrl.mem_w_en     = bus.mem_w_en_in;
    in_ctrl.branch_taken = bus.branch_taken_in;
  end

  assign out_free = !(out_valid_q && bus.out_stall);
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (bus.flush),
    .a       (bus.val_rn),
    .b       (bus.val_rm),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Controller: a retire (load) writes the output register and the status.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    dest_d      = dest_q;
    res_d       = res_q;
    rm_d        = rm_q;
    br_d        = br_q;
    status_d    = status_q;
    m_ctrl_d    = m_ctrl_q;
    m_swe_d     = m_swe_q;
    m_dest_d    = m_dest_q;
    m_rm_d      = m_rm_q;
    m_br_d      = m_br_q;
    mul_start   = 1'b0;
    load        = 1'b0;

    if (bus.flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && bus.exe_cmd == CMD_MUL) begin
            m_ctrl_d  = in_ctrl;
            m_swe_d   = bus.status_w_en_in;
            m_dest_d  = bus.dest_in;
            m_rm_d    = bus.val_rm;
            m_br_d    = br_addr;
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else if (accept) begin
            load       = 1'b1;
            out_ctrl_d = in_ctrl;
            dest_d     = bus.dest_in;
            res_d      = alu_res;
            rm_d       = bus.val_rm;
            br_d       = br_addr;
            if (bus.status_w_en_in && alu_flag_we) status_d = alu_nzcv;
          end
        end
        ST_MUL: begin
          if (mul_done) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_free) begin
            load       = 1'b1;
            out_ctrl_d = m_ctrl_q;
            dest_d     = m_dest_q;
            res_d      = mul_product;
            rm_d       = m_rm_q;
            br_d       = m_br_q;
            if (m_swe_q) begin
              status_d[FLAG_N] = mul_product[DATA_W-1];
              status_d[FLAG_Z] = (mul_product == '0);
            end
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (load)          out_valid_d = 1'b1;
      else if (out_free) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      dest_q      <= '0;
      res_q       <= '0;
      rm_q        <= '0;
      br_q        <= '0;
      status_q    <= '0;
      m_ctrl_q    <= '0;
      m_swe_q     <= 1'b0;
      m_dest_q    <= '0;
      m_rm_q      <= '0;
      m_br_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      dest_q      <= dest_d;
      res_q       <= res_d;
      rm_q        <= rm_d;
      br_q        <= br_d;
      status_q    <= status_d;
      m_ctrl_q    <= m_ctrl_d;
      m_swe_q     <= m_swe_d;
      m_dest_q    <= m_dest_d;
      m_rm_q      <= m_rm_d;
      m_br_q      <= m_br_d;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = out_valid_q;
  assign bus.wb_en_out        = out_ctrl_q.wb_en;
  assign bus.mem_r_en_out     = out_ctrl_q.mem_r_en;
  assign bus.mem_w_en_out     = out_ctrl_q.mem_w_en;
  assign bus.branch_taken_out = out_ctrl_q.branch_taken;
  assign bus.dest_out         = dest_q;
  assign bus.alu_res          = res_q;
  assign bus.val_rm_out       = rm_q;
  assign bus.branch_address   = br_q;
  assign bus.status           = status_q;

  // The multiplier's busy flag mirrors ST_MUL and is kept only for observability.
  logic unused_mul_busy;
  assign unused_mul_busy = mul_busy;

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage with a built-in EX/MEM output register, a valid/ready upstream handshake, downstream stall and flush, an internal NZCV status register and an iterative multi-cycle multiplier. It sits between the ID/EX register and the memory stage. It computes the ALU result, the store data pass-through and the sign-extended branch target. Unlike the single-cycle combinational execute stage, it feeds the live carry flag into ADC/SBC and can hold the pipeline while a multiply is in progress.

## Interface
Parameters:
- DATA_W, 32: operand/result width; must be ≥16 and a power of two.
- ADDR_W, 32: PC and branch address width.
- REG_ADDR_W, 4: destination register address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the stage accepts on this edge when in_valid && in_ready.
- pc_in  in  ADDR_W  PC of the instruction (already +4).
- wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in, branch_taken_in  in  1 each  control bits.
- immd  in  1  val2 comes from the rotated immediate.
- exe_cmd  in  4  ALU command; encodings in ex_pkg.
- val_rn, val_rm  in  DATA_W  operands.
- dest_in  in  REG_ADDR_W  destination register.
- signed_immd_24  in  24  branch offset in words.
- shift_operand  in  12  ARM shifter operand field.
- out_stall  in  1  the memory stage cannot take the output register.
- flush  in  1  kill in-flight and presented work.
- out_valid  out  1  the output register holds a valid instruction.
- wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out  out  1 each  registered control bits.
- dest_out  out  REG_ADDR_W; alu_res, val_rm_out  out  DATA_W; branch_address  out  ADDR_W  registered results.
- status  out  4  current NZCV (N=3, Z=2, C=1, V=0).

## Operation
- Val2 rules:
  - If mem_r_en_in or mem_w_en_in is set, val2 = zero-extended shift_operand[11:0].
  - Else if immd is set, val2 = {0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Else val2 = val_rm shifted by type shift_operand[6:5] (LSL, LSR, ASR, ROR) by amount shift_operand[11:7], taken modulo DATA_W.
- ALU commands:
  - MOV 0001 and MVN 1001 use val2 (MVN inverted).
  - ADD 0010, ADC 0011 (+C), SUB 0100, SBC 0101 (−!C).
  - AND 0110, ORR 0111, EOR 1000.
  - MUL 1010 gives the low DATA_W bits of val_rn*val_rm.
  - Any other code gives a result of 0 with no flag change.
- Flags:
  - N = msb, Z = result==0.
  - C and V are set for arithmetic commands only; logic commands and MOV/MVN keep the old C and V; MUL updates N and Z only.
  - The status register updates on the retire edge when status_w_en_in is set.
- branch_address = pc_in + (sign-extended signed_immd_24 << 2), truncated to ADDR_W.
- Controller FSM:
  - IDLE: on accept of a non-MUL instruction, load the output register.
  - IDLE: on accept of a MUL, latch the operands and controls and go to MUL.
  - MUL: one shift-add step per cycle for DATA_W cycles, then go to DONE.
  - DONE: when the output register is free (!out_valid || !out_stall), load it, retire the status update, and go to IDLE.
- in_ready = (state==IDLE) && !(out_valid && out_stall).
- Output register:
  - Holds its contents while out_valid && out_stall.
  - Otherwise it is loaded when there is a retire, or out_valid goes to 0.
- Flush (synchronous):
  - Clears out_valid and aborts MUL/DONE to IDLE.
  - Suppresses any accept and any status write on that edge.
  - Takes priority over out_stall.

## Timing
- Reset values:
  - out_valid, all control outputs, dest_out, alu_res, val_rm_out, branch_address and status are 0.
  - FSM is in IDLE; in_ready is 1 after reset release.
- Non-MUL latency: accept at edge k gives out_valid=1 after edge k. Back-to-back throughput is 1 per cycle.
- MUL latency:
  - Accept at edge k; in_ready=0 from then until the FSM returns to IDLE.
  - Result appears after edge k+DATA_W+1 when there is no stall (33 cycles for DATA_W=32).
- Carry for ADC/SBC is the status value registered before the accept edge. There is no internal bypass from the instruction currently retiring.
- Reset asserted mid-MUL aborts immediately and asynchronously to the reset values.

## Structure
- ex_pkg holds the exe_cmd encodings, the shift-type codes, the FSM state enum and the flag bit indices.
- The sub-module ex_mul_seq is the iterative multiplier (start, operands, busy, done, product). It is parametrised by DATA_W.
- The shifter and ALU are combinational in the top module.

## Test plan
- ADD val_rn=5, val_rm=3 (register, LSL #0), status_w_en=1 -> alu_res=8 and status=0000 one cycle after accept.
- SUB 3−5 with status_w_en -> alu_res=0xFFFFFFFE, N=1, C=0. A following ADC 1+1 -> 2; after SUB 5−3 (C=1), ADC 1+1 -> 3.
- MUL 7*6 -> in_ready low for 33 cycles; alu_res=42 with out_valid after edge k+33. A second instruction is accepted the next cycle.
- out_stall held 3 cycles with back-to-back ADDs -> output register frozen, in_ready=0, no instruction lost or duplicated.
- flush during the MUL state, and separately rst low mid-MUL -> out_valid=0, FSM in IDLE, status unchanged (reset case: 0).
- pc_in=100 with signed_immd_24=0xFFFFFF -> branch_address=96. With immd=1 and shift_operand=0x1FF -> alu_res=0xC000003F.
